// File: rtl/mux_arb_pkg.sv
// Shared types and defaults for the round-robin mux arbiter.
// The optional burst lock is enabled by defining MUX_ARB_LOCK_EN.
package mux_arb_pkg;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  localparam int N_REQ_DEF = 4;
  localparam int W_DEF     = 8;

  // Index width for a requester count; never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mux_rr_arbiter_rr_pick.sv
// Rotating-priority encoder: the first requester after ptr wins, or only
// the locked requester is considered while a burst is in progress.
module rr_pick import mux_arb_pkg::*; #(
  parameter int N_REQ = N_REQ_DEF,
  parameter int IW    = idx_w(N_REQ_DEF)
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [IW-1:0]    i_ptr,
  input  logic             i_lock,
  input  logic [IW-1:0]    i_lock_idx,
  output logic [N_REQ-1:0] o_grant,
  output logic [IW-1:0]    o_idx,
  output logic             o_any
);

  int w_cand;

  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    o_any   = 1'b0;
    w_cand  = 0;
    if (i_lock) begin
      if (i_req[i_lock_idx]) begin
        o_grant[i_lock_idx] = 1'b1;
        o_idx               = i_lock_idx;
        o_any               = 1'b1;
      end
    end else begin
      // Scan ptr+1 .. ptr+N_REQ so the last winner has lowest priority.
      for (int k = 1; k <= N_REQ; k++) begin
        w_cand = (int'(i_ptr) + k) % N_REQ;
        if (!o_any && i_req[w_cand]) begin
          o_grant[w_cand] = 1'b1;
          o_idx           = IW'(w_cand);
          o_any           = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter sharing one N-way data mux into a registered output.
// Define MUX_ARB_LOCK_EN to add req_last and hold the grant for whole bursts.
module mux_rr_arbiter import mux_arb_pkg::*; #(
  parameter  int N_REQ = N_REQ_DEF,
  parameter  int W     = W_DEF,
  localparam int IW    = idx_w(N_REQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [N_REQ*W-1:0] req_data,
`ifdef MUX_ARB_LOCK_EN
  input  logic [N_REQ-1:0]   req_last,
`endif
  output logic [N_REQ-1:0]   req_ready,
  output logic               out_valid,
  output logic [W-1:0]       out_data,
  output logic [IW-1:0]      out_src,
  input  logic               out_ready
);

  state_t           r_state;
  state_t           w_state_next;
  logic [W-1:0]     r_out_data;
  logic [IW-1:0]    r_out_src;
  logic [IW-1:0]    r_ptr;

  logic [N_REQ-1:0] w_grant;
  logic [IW-1:0]    w_idx;
  logic             w_any;
  logic             w_can_load;
  logic             w_xfer;
  logic [W-1:0]     w_mux_data;
  logic             w_lock;
  logic [IW-1:0]    w_lock_idx;

`ifdef MUX_ARB_LOCK_EN
  logic             r_lock;
  logic [IW-1:0]    r_lock_idx;
  assign w_lock     = r_lock;
  assign w_lock_idx = r_lock_idx;
`else
  assign w_lock     = 1'b0;
  assign w_lock_idx = '0;
`endif

  rr_pick #(
    .N_REQ (N_REQ),
    .IW    (IW)
  ) u_pick (
    .i_req      (req_valid),
    .i_ptr      (r_ptr),
    .i_lock     (w_lock),
    .i_lock_idx (w_lock_idx),
    .o_grant    (w_grant),
    .o_idx      (w_idx),
    .o_any      (w_any)
  );

  assign w_can_load = (r_state == EMPTY) || out_ready;
  assign req_ready  = (w_any && w_can_load && !rst) ? w_grant : '0;
  assign w_xfer     = |(req_valid & req_ready);
  assign w_mux_data = req_data[w_idx*W +: W];

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      EMPTY:   if (w_xfer) w_state_next = FULL;
      FULL:    if (w_xfer) w_state_next = FULL;
               else if (out_ready) w_state_next = EMPTY;
      default: w_state_next = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= EMPTY;
      r_out_data <= '0;
      r_out_src  <= '0;
      r_ptr      <= IW'(N_REQ - 1);
`ifdef MUX_ARB_LOCK_EN
      r_lock     <= 1'b0;
      r_lock_idx <= '0;
`endif
    end else begin
      r_state <= w_state_next;
      if (w_xfer) begin
        r_out_data <= w_mux_data;
        r_out_src  <= w_idx;
`ifdef MUX_ARB_LOCK_EN
        // Pointer moves only when a burst closes so rotation is per burst.
        if (req_last[w_idx]) begin
          r_lock <= 1'b0;
          r_ptr  <= w_idx;
        end else begin
          r_lock     <= 1'b1;
          r_lock_idx <= w_idx;
        end
`else
        r_ptr <= w_idx;
`endif
      end
    end
  end

  assign out_valid = (r_state == FULL);
  assign out_data  = r_out_data;
  assign out_src   = r_out_src;

endmodule
